// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU data-bus controller.
// FSM state encoding, captured request bundle and address alignment mask.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } dbus_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        we;
    } dbus_req_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/cpu_dbus_ctrl.sv
// Data-bus controller: captures a CPU load/store and runs it on a
// req/gnt/rvalid memory port, returning a registered word on bus_rdata.
// Ports: clk, rst (sync, active-high); CPU side bus_addr/wdata/wmask/
// ren/wen in, bus_rdata/done/err out; memory side mem_req/we/addr/
// wdata/wmask out, mem_gnt/rvalid/rdata in.
module cpu_dbus_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wmask,
    input  logic        bus_ren,
    input  logic        bus_wen,
    output logic [31:0] bus_rdata,
    output logic        bus_done,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    dbus_state_t state_q, state_d;
    dbus_req_t   req_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        timeout;
    logic        to_hit;

    assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Completion has priority over timeout in the last allowed cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                accept  = bus_ren | bus_wen;
                state_d = accept ? REQ : IDLE;
            end
            REQ: begin
                if (mem_gnt && req_q.we) begin
                    state_d = DONE;
                end else if (to_hit) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end else if (mem_gnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_d = DONE;
                end else if (to_hit) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= timeout;
            if (accept) begin
                // A simultaneous ren/wen is resolved as a write.
                req_q.addr  <= bus_addr & WORD_ALIGN_MASK;
                req_q.wdata <= bus_wdata;
                req_q.wmask <= bus_wmask;
                req_q.we    <= bus_wen;
                cnt_q       <= '0;
            end else if (state_q == REQ || state_q == RESP) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == RESP && mem_rvalid) begin
                rdata_q <= mem_rdata;
            end else if (timeout && !req_q.we) begin
                rdata_q <= ERR_RDATA;
            end
        end
    end

    assign bus_done  = (state_q == IDLE) || (state_q == DONE);
    assign bus_err   = (state_q == DONE) && err_q;
    assign bus_rdata = rdata_q;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = req_q.we;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_wmask = req_q.wmask;

    a_gnt_rvalid: assert property (
        @(posedge clk) disable iff (rst) !(mem_gnt && mem_rvalid));

    a_ren_wen: assert property (
        @(posedge clk) disable iff (rst) !(bus_ren && bus_wen));

endmodule

// File: tb/tb_cpu_dbus_ctrl.sv
// Testbench for cpu_dbus_ctrl: directed accesses plus constrained random
// traffic, completions checked by a scoreboard monitor.
module tb_cpu_dbus_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] bus_rdata;
    logic        bus_done;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    cpu_dbus_ctrl #(
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA(32'hFFFF_FFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_wmask(bus_wmask),
        .bus_ren(bus_ren),
        .bus_wen(bus_wen),
        .bus_rdata(bus_rdata),
        .bus_done(bus_done),
        .bus_err(bus_err),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dev_mem [logic [31:0]];

    int busy_run  = 0;
    int last_busy = 0;
    int req_wait;
    int req_cycles;
    int stable_bad;
    logic [31:0] addr_seen;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] upd(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0]  wm);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Completion monitor: first done cycle after a busy run.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run = 0;
        end else if (!bus_done) begin
            busy_run++;
        end else if (busy_run > 0) begin
            last_busy = busy_run;
            busy_run  = 0;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: completion with no expected entry");
            end else begin
                e = exp_q.pop_front();
                check("sb_rdata", bus_rdata, e.rdata);
                check("sb_err", {31'b0, bus_err}, {31'b0, e.err});
            end
        end
    end

    // CPU request plus memory responder for one access.
    // Entered and left at a negedge; on exit the DUT is in DONE.
    task automatic access(input bit we,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          input logic [3:0]  wm,
                          input int gd,
                          input int rd);
        logic [31:0] wa;
        logic [31:0] rv;
        exp_t e;
        int n;
        wa = a & 32'hFFFF_FFFC;
        rv = '0;
        bus_addr  = a;
        bus_wdata = wd;
        bus_wmask = wm;
        bus_ren   = !we;
        bus_wen   = we;
        if (we) ref_mem[wa] = upd(ref_mem[wa], wd, wm);
        else    exp_rdata = ref_mem[wa];
        e.rdata = exp_rdata;
        e.err   = 1'b0;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 10);
        req_wait   = n;
        addr_seen  = mem_addr;
        req_cycles = 0;
        stable_bad = 0;
        for (int i = 0; i <= gd; i++) begin
            if (i > 0) @(negedge clk);
            if (mem_req) req_cycles++;
            if (mem_addr !== wa || mem_we !== we) stable_bad++;
            if (we && (mem_wdata !== wd || mem_wmask !== wm))
                stable_bad++;
        end
        mem_gnt = 1'b1;
        if (we) dev_mem[mem_addr] = upd(dev_mem[mem_addr],
                                        mem_wdata, mem_wmask);
        else    rv = dev_mem[mem_addr];
        @(negedge clk);
        mem_gnt = 1'b0;
        if (!we) begin
            repeat (rd - 1) @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = rv;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        bus_ren = 1'b0;
        bus_wen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int n;
        bit we;
        logic [31:0] a, wd;
        logic [3:0] wm;
        int gd, rd;

        rst = 1'b1;
        bus_addr = '0; bus_wdata = '0; bus_wmask = '0;
        bus_ren = 1'b0; bus_wen = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            ref_mem[32'h1000_0000 + 4*i] = 32'h0101_0101 * (i + 1);
            ref_mem[32'h2000_0000 + 4*i] = 32'h1111_0000 + i;
        end
        ref_mem[32'h1000_0004] = 32'hA5A5_1234;
        dev_mem = ref_mem;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_done", bus_done, 1);
        check("rst_err", bus_err, 0);
        check("rst_rdata", bus_rdata, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);

        // T1: minimum-latency read
        access(0, 32'h1000_0006, '0, '0, 0, 1);
        check("t1_addr", addr_seen, 32'h1000_0004);
        check("t1_req_wait", req_wait, 1);
        @(negedge clk);
        check("t1_busy", last_busy, 2);
        check("t1_rdata", bus_rdata, 32'hA5A5_1234);

        // T2: store with delayed gnt
        access(1, 32'h1000_0008, 32'h0000_BEEF, 4'b0011, 3, 1);
        check("t2_req_off", mem_req, 0);
        check("t2_done", bus_done, 1);
        check("t2_req_cycles", req_cycles, 4);
        check("t2_stable", stable_bad, 0);
        @(negedge clk);
        check("t2_busy", last_busy, 4);
        check("t2_rdata_held", bus_rdata, 32'hA5A5_1234);

        // T3: back-to-back loads
        access(0, 32'h2000_0000, '0, '0, 0, 1);
        check("t3_done_gap", bus_done, 1);
        access(0, 32'h2000_0008, '0, '0, 1, 2);
        check("t3_b2b", req_wait, 1);
        check("t3_addr2", addr_seen, 32'h2000_0008);
        @(negedge clk);

        // T4: read never granted
        bus_ren  = 1'b1;
        bus_addr = 32'h1000_0000;
        exp_rdata = 32'hFFFF_FFFF;
        e.rdata = exp_rdata;
        e.err   = 1'b1;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_done && n < 20);
        check("t4_cycles", n, 9);
        check("t4_err", bus_err, 1);
        check("t4_req_off", mem_req, 0);
        check("t4_rdata", bus_rdata, 32'hFFFF_FFFF);
        bus_ren = 1'b0;
        @(negedge clk);
        check("t4_err_pulse", bus_err, 0);

        // T5: reset during RESP, late rvalid ignored
        bus_ren  = 1'b1;
        bus_addr = 32'h1000_0004;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 10);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("t5_in_resp", bus_done, 0);
        rst = 1'b1;
        bus_ren = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        exp_rdata  = '0;
        check("t5_rdata", bus_rdata, 0);
        check("t5_done", bus_done, 1);
        check("t5_req", mem_req, 0);
        @(negedge clk);
        check("t5_no_err", bus_err, 0);
        check("t5_rdata2", bus_rdata, 0);

        // T6: random traffic within the timeout window
        for (int k = 0; k < 40; k++) begin
            we = 1'($urandom_range(0, 1));
            a  = 32'h2000_0000 | (32'($urandom_range(0, 3)) << 2)
                 | 32'($urandom_range(0, 3));
            wd = $urandom;
            wm = 4'($urandom_range(1, 15));
            gd = $urandom_range(0, 5);
            rd = $urandom_range(1, 7 - gd);
            if (!we) begin
                wd = '0;
                wm = '0;
            end
            access(we, a, wd, wm, gd, rd);
            check("t6_stable", stable_bad, 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
